// File: rtl/m4sram_transpose_ctrl_pkg.sv
// Shared definitions for the M4SRAM corner-turn controller.
//   NBANK : number of SRAM banks (fixed by the memory)
//   AW    : per-bank address width (depth 4)
//   DW    : default sample / SRAM word width, {re[31:0], im[31:0]}
//   state_t : controller phases FILL -> PRIME -> DRAIN -> FILL
package m4sram_pkg;

  localparam int unsigned NBANK = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/m4sram_transpose_ctrl_lane_rot4.sv
// Four-lane rotator: lanes_out[i] = lanes_in[(i + k) % 4].
// A left rotate by k; a right rotate is obtained by passing k = -k (mod 4).
// Ports:
//   k         in  2       rotate amount
//   lanes_in  in  4 x DW  input lanes
//   lanes_out out 4 x DW  rotated lanes
module lane_rot4 #(
  parameter int unsigned DW = 64
) (
  input  logic [1:0]         k,
  input  logic [3:0][DW-1:0] lanes_in,
  output logic [3:0][DW-1:0] lanes_out
);

  always_comb begin
    lanes_out = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lanes_out[i] = lanes_in[2'(i + 32'(k))];
    end
  end

endmodule

// File: rtl/m4sram_transpose_ctrl.sv
// Initiator for the four-bank M4SRAM performing a 4x4 corner turn.
// A block arrives as 4 row beats (lane c = column c) and leaves as 4 column
// beats (lane r = row r). Element (r,c) lives in bank (c+r)%4 at address r,
// so every row write and every column read touches each bank exactly once.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   IN_VALID/IN_READY row beat handshake, IN_D0..3 row lanes
//   OUT_VALID/OUT_READY column beat handshake, OUT_Q0..3 column lanes
//   WE                SRAM write enable (shared)
//   ADDR0..3, D0..3   per-bank SRAM address / write data
//   Q0..3             per-bank SRAM read data (1-cycle latency)
module m4sram_transpose_ctrl
  import m4sram_pkg::*;
#(
  parameter int unsigned DW = m4sram_pkg::DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_D0,
  input  logic [DW-1:0] IN_D1,
  input  logic [DW-1:0] IN_D2,
  input  logic [DW-1:0] IN_D3,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_Q0,
  output logic [DW-1:0] OUT_Q1,
  output logic [DW-1:0] OUT_Q2,
  output logic [DW-1:0] OUT_Q3,
  output logic          WE,
  output logic [AW-1:0] ADDR0,
  output logic [AW-1:0] ADDR1,
  output logic [AW-1:0] ADDR2,
  output logic [AW-1:0] ADDR3,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic [DW-1:0] D2,
  output logic [DW-1:0] D3,
  input  logic [DW-1:0] Q0,
  input  logic [DW-1:0] Q1,
  input  logic [DW-1:0] Q2,
  input  logic [DW-1:0] Q3
);

  state_t state, state_next;
  logic [1:0] rc, rc_next;
  logic [1:0] cc, cc_next;

  logic in_ready, out_valid, we;
  logic in_hs, out_hs;
  logic [1:0] rd_k;
  logic [NBANK-1:0][AW-1:0] addr;
  logic [NBANK-1:0][DW-1:0] d_bank;

  logic [3:0][DW-1:0] in_lanes, wr_lanes;
  logic [3:0][DW-1:0] q_lanes, out_lanes;

  assign in_hs  = IN_VALID & in_ready;
  assign out_hs = out_valid & OUT_READY;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FILL;
      rc    <= '0;
      cc    <= '0;
    end else begin
      state <= state_next;
      rc    <= rc_next;
      cc    <= cc_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state;
    rc_next    = rc;
    cc_next    = cc;
    case (state)
      FILL: begin
        if (in_hs) begin
          rc_next = rc + 2'd1;
          if (rc == 2'd3) state_next = PRIME;
        end
      end
      PRIME: begin
        state_next = DRAIN;
        cc_next    = '0;
      end
      DRAIN: begin
        if (out_hs) begin
          cc_next = cc + 2'd1;
          if (cc == 2'd3) state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Read column k lives at address (b-k)%4 in bank b. During DRAIN the
  // address looks one column ahead on a handshake and repeats the current
  // column otherwise, so Q always holds the column shown on OUT_Q.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    we        = 1'b0;
    rd_k      = '0;
    addr      = '0;
    d_bank    = '0;
    case (state)
      FILL: begin
        in_ready = ~RST;
        we       = IN_VALID & ~RST;
        d_bank   = wr_lanes;
        for (int unsigned b = 0; b < NBANK; b++) addr[b] = rc;
      end
      PRIME: begin
        rd_k = '0;
        for (int unsigned b = 0; b < NBANK; b++) addr[b] = 2'(b) - rd_k;
      end
      DRAIN: begin
        out_valid = ~RST;
        rd_k      = OUT_READY ? (cc + 2'd1) : cc;
        for (int unsigned b = 0; b < NBANK; b++) addr[b] = 2'(b) - rd_k;
      end
      default: ;
    endcase
  end

  // Write skew: bank b takes IN_D[(b-rc)%4], i.e. rotate by -rc.
  assign in_lanes = {IN_D3, IN_D2, IN_D1, IN_D0};

  lane_rot4 #(.DW(DW)) u_wr_rot (
    .k         (2'd0 - rc),
    .lanes_in  (in_lanes),
    .lanes_out (wr_lanes)
  );

  // Read de-skew: row r of column cc sits in bank (r+cc)%4.
  assign q_lanes = {Q3, Q2, Q1, Q0};

  lane_rot4 #(.DW(DW)) u_rd_rot (
    .k         (cc),
    .lanes_in  (q_lanes),
    .lanes_out (out_lanes)
  );

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid;
  assign WE        = we;
  assign ADDR0     = addr[0];
  assign ADDR1     = addr[1];
  assign ADDR2     = addr[2];
  assign ADDR3     = addr[3];
  assign D0        = d_bank[0];
  assign D1        = d_bank[1];
  assign D2        = d_bank[2];
  assign D3        = d_bank[3];
  assign OUT_Q0    = out_lanes[0];
  assign OUT_Q1    = out_lanes[1];
  assign OUT_Q2    = out_lanes[2];
  assign OUT_Q3    = out_lanes[3];

endmodule

// File: tb/tb_m4sram_transpose_ctrl.sv
// Directed bench for m4sram_transpose_ctrl with a behavioural M4SRAM on the
// memory ports (write when WE=1, registered read when WE=0, Q held on writes).
module tb_m4sram_transpose_ctrl;

  logic CLK = 1'b0;
  logic RST, IN_VALID, OUT_READY;
  logic [63:0] in_d [4];
  logic IN_READY, OUT_VALID, WE;
  logic [63:0] out_q [4];
  logic [1:0]  ADDR0, ADDR1, ADDR2, ADDR3;
  logic [63:0] D0, D1, D2, D3;
  logic [63:0] q [4];
  logic [63:0] mem [4][4];

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic        snap_we;
  logic [1:0]  snap_addr [4];
  logic [63:0] snap_d [4];
  int unsigned hs_cyc, out_cyc;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  m4sram_transpose_ctrl #(.DW(64)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_D0(in_d[0]), .IN_D1(in_d[1]), .IN_D2(in_d[2]), .IN_D3(in_d[3]),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_Q0(out_q[0]), .OUT_Q1(out_q[1]), .OUT_Q2(out_q[2]), .OUT_Q3(out_q[3]),
    .WE(WE),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3])
  );

  // M4SRAM behaviour
  always @(posedge CLK) begin
    if (WE) begin
      mem[0][ADDR0] <= D0; mem[1][ADDR1] <= D1;
      mem[2][ADDR2] <= D2; mem[3][ADDR3] <= D3;
    end else begin
      q[0] <= mem[0][ADDR0]; q[1] <= mem[1][ADDR1];
      q[2] <= mem[2][ADDR2]; q[3] <= mem[3][ADDR3];
    end
  end

  function automatic logic [63:0] elem(input int blk, input int r, input int c);
    return 64'(blk * 256 + r * 16 + c);
  endfunction

  // Presents one row until it is accepted; snapshots the memory-side outputs.
  task automatic push_row(input int blk, input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      for (int c = 0; c < 4; c++) in_d[c] = elem(blk, r, c);
      #1;
      if (IN_READY) begin
        snap_we = WE;
        snap_addr[0] = ADDR0; snap_addr[1] = ADDR1; snap_addr[2] = ADDR2; snap_addr[3] = ADDR3;
        snap_d[0] = D0; snap_d[1] = D1; snap_d[2] = D2; snap_d[3] = D3;
        hs_cyc = cyc;
        ok = 1'b1;
        @(posedge CLK);
        break;
      end
    end
  endtask

  // Waits for one column beat with OUT_READY=1; busy counts cycles where
  // the input side was open or a write was issued.
  task automatic collect_col(output logic [3:0][63:0] col, output bit ok, output int unsigned busy);
    ok = 1'b0; busy = 0; col = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      OUT_READY = 1'b1;
      #1;
      if (IN_READY || WE) busy++;
      if (OUT_VALID) begin
        for (int r = 0; r < 4; r++) col[r] = out_q[r];
        out_cyc = cyc;
        ok = 1'b1;
        @(posedge CLK);
        break;
      end
    end
  endtask

  task automatic fill_block(input int blk, output bit ok);
    bit k;
    ok = 1'b1;
    for (int r = 0; r < 4; r++) begin
      push_row(blk, r, k);
      ok = ok & k;
    end
  endtask

  task automatic drain_block(output logic [3:0][3:0][63:0] bo, output bit ok, output int unsigned busy);
    bit k;
    int unsigned b;
    logic [3:0][63:0] col;
    ok = 1'b1; busy = 0; bo = '0;
    for (int c = 0; c < 4; c++) begin
      collect_col(col, k, b);
      bo[c] = col;
      ok = ok & k;
      busy += b;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b0;
    for (int c = 0; c < 4; c++) in_d[c] = 64'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      n_cmp++; if (WE !== 1'b0) begin n_bad++; $display("FAIL reset_we cyc%0d: got %b want 0", i, WE); end
      n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", i, IN_READY); end
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, OUT_VALID); end
    end
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", IN_READY); end
  endtask

  task automatic test_basic();
    bit ok;
    int unsigned busy;
    logic [3:0][3:0][63:0] bo;
    for (int r = 0; r < 4; r++) begin
      push_row(0, r, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_row%0d_accept: got timeout want handshake", r); end
      if (r == 1) begin
        n_cmp++; if (snap_we !== 1'b1) begin n_bad++; $display("FAIL basic_row1_we: got %b want 1", snap_we); end
        n_cmp++; if (snap_d[1] !== 64'h10) begin n_bad++; $display("FAIL basic_row1_d1: got %h want 10", snap_d[1]); end
        n_cmp++; if (snap_d[0] !== 64'h13) begin n_bad++; $display("FAIL basic_row1_d0: got %h want 13", snap_d[0]); end
        for (int b = 0; b < 4; b++) begin
          n_cmp++; if (snap_addr[b] !== 2'd1) begin n_bad++; $display("FAIL basic_row1_addr%0d: got %0d want 1", b, snap_addr[b]); end
        end
      end
    end
    @(negedge CLK); IN_VALID = 1'b0; #1;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL basic_prime_out_valid: got %b want 0", OUT_VALID); end
    @(negedge CLK); #1;
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL basic_latency_out_valid: got %b want 1", OUT_VALID); end
    drain_block(bo, ok, busy);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_drain: got timeout want 4 beats"); end
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (bo[0][r] !== 64'(r * 16)) begin n_bad++; $display("FAIL basic_beat0_lane%0d: got %h want %h", r, bo[0][r], 64'(r * 16)); end
      n_cmp++; if (bo[3][r] !== 64'(r * 16 + 3)) begin n_bad++; $display("FAIL basic_beat3_lane%0d: got %h want %h", r, bo[3][r], 64'(r * 16 + 3)); end
    end
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (bo[1][r] !== 64'(r * 16 + 1)) begin n_bad++; $display("FAIL basic_beat1_lane%0d: got %h want %h", r, bo[1][r], 64'(r * 16 + 1)); end
      n_cmp++; if (bo[2][r] !== 64'(r * 16 + 2)) begin n_bad++; $display("FAIL basic_beat2_lane%0d: got %h want %h", r, bo[2][r], 64'(r * 16 + 2)); end
    end
  endtask

  task automatic test_bubbles();
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int row = 0;
    bit ok;
    int unsigned busy;
    logic [3:0][3:0][63:0] bo;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      IN_VALID = (pat[i] != 0);
      for (int c = 0; c < 4; c++) in_d[c] = (pat[i] != 0) ? elem(0, row, c) : 64'hBAD0 + 64'(c);
      #1;
      n_cmp++; if (WE !== IN_VALID) begin n_bad++; $display("FAIL bubbles_we_step%0d: got %b want %b", i, WE, IN_VALID); end
      if (pat[i] != 0) begin
        n_cmp++; if (ADDR2 !== 2'(row)) begin n_bad++; $display("FAIL bubbles_addr_step%0d: got %0d want %0d", i, ADDR2, row); end
        row++;
      end
      @(posedge CLK);
    end
    @(negedge CLK); IN_VALID = 1'b0;
    drain_block(bo, ok, busy);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bubbles_drain: got timeout want 4 beats"); end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        n_cmp++; if (bo[c][r] !== elem(0, r, c)) begin n_bad++; $display("FAIL bubbles_col%0d_lane%0d: got %h want %h", c, r, bo[c][r], elem(0, r, c)); end
      end
  endtask

  task automatic test_backpressure();
    bit ok, k;
    int unsigned busy;
    logic [3:0][63:0] col;
    logic [1:0] exp_addr [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] got_addr [4];
    fill_block(0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_fill: got timeout want 4 handshakes"); end
    @(negedge CLK); IN_VALID = 1'b0;
    collect_col(col, k, busy);
    collect_col(col, k, busy);
    n_cmp++; if (!k) begin n_bad++; $display("FAIL bp_col1: got timeout want beat"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); OUT_READY = 1'b0; #1;
      got_addr[0] = ADDR0; got_addr[1] = ADDR1; got_addr[2] = ADDR2; got_addr[3] = ADDR3;
      n_cmp++; if (OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_cyc%0d: got %b want 1", i, OUT_VALID); end
      n_cmp++; if (WE !== 1'b0) begin n_bad++; $display("FAIL bp_we_cyc%0d: got %b want 0", i, WE); end
      for (int r = 0; r < 4; r++) begin
        n_cmp++; if (out_q[r] !== 64'(r * 16 + 2)) begin n_bad++; $display("FAIL bp_q%0d_cyc%0d: got %h want %h", r, i, out_q[r], 64'(r * 16 + 2)); end
        n_cmp++; if (got_addr[r] !== exp_addr[r]) begin n_bad++; $display("FAIL bp_addr%0d_cyc%0d: got %0d want %0d", r, i, got_addr[r], exp_addr[r]); end
      end
    end
    collect_col(col, k, busy);
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (col[r] !== 64'(r * 16 + 2)) begin n_bad++; $display("FAIL bp_col2_lane%0d: got %h want %h", r, col[r], 64'(r * 16 + 2)); end
    end
    collect_col(col, k, busy);
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (col[r] !== 64'(r * 16 + 3)) begin n_bad++; $display("FAIL bp_col3_lane%0d: got %h want %h", r, col[r], 64'(r * 16 + 3)); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int unsigned busy, first_a, first_b;
    logic [3:0][3:0][63:0] bo_a, bo_b;
    OUT_READY = 1'b1;
    push_row(1, 0, ok);
    first_a = hs_cyc;
    for (int r = 1; r < 4; r++) push_row(1, r, ok);
    drain_block(bo_a, ok, busy);
    n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL b2b_a_input_closed: got %0d open cycles want 0", busy); end
    push_row(2, 0, ok);
    first_b = hs_cyc;
    n_cmp++; if (first_b - first_a !== 32'd9) begin n_bad++; $display("FAIL b2b_block_period: got %0d want 9", first_b - first_a); end
    for (int r = 1; r < 4; r++) push_row(2, r, ok);
    drain_block(bo_b, ok, busy);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_drain: got timeout want 4 beats"); end
    n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL b2b_b_input_closed: got %0d open cycles want 0", busy); end
    n_cmp++; if (out_cyc - first_a !== 32'd17) begin n_bad++; $display("FAIL b2b_two_block_span: got %0d want 17", out_cyc - first_a); end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        n_cmp++; if (bo_a[c][r] !== elem(1, r, c)) begin n_bad++; $display("FAIL b2b_a_col%0d_lane%0d: got %h want %h", c, r, bo_a[c][r], elem(1, r, c)); end
        n_cmp++; if (bo_b[c][r] !== elem(2, r, c)) begin n_bad++; $display("FAIL b2b_b_col%0d_lane%0d: got %h want %h", c, r, bo_b[c][r], elem(2, r, c)); end
      end
    @(negedge CLK); IN_VALID = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok, k;
    int unsigned busy;
    logic [3:0][63:0] col;
    logic [3:0][3:0][63:0] bo;
    fill_block(6, ok);
    @(negedge CLK); IN_VALID = 1'b0;
    collect_col(col, k, busy);
    n_cmp++; if (col[1] !== elem(6, 1, 0)) begin n_bad++; $display("FAIL rmid_col0_lane1: got %h want %h", col[1], elem(6, 1, 0)); end
    @(negedge CLK); OUT_READY = 1'b0; RST = 1'b1; #1;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rmid_in_reset_out_valid: got %b want 0", OUT_VALID); end
    @(negedge CLK); RST = 1'b0; #1;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rmid_after_out_valid: got %b want 0", OUT_VALID); end
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL rmid_after_in_ready: got %b want 1", IN_READY); end
    fill_block(7, ok);
    @(negedge CLK); IN_VALID = 1'b0;
    drain_block(bo, ok, busy);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_drain: got timeout want 4 beats"); end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        n_cmp++; if (bo[c][r] !== elem(7, r, c)) begin n_bad++; $display("FAIL rmid_col%0d_lane%0d: got %h want %h", c, r, bo[c][r], elem(7, r, c)); end
      end
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    for (int c = 0; c < 4; c++) in_d[c] = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
